// File: rtl/cdctl_qspi_host.sv
`default_nettype none
// cdctl_qspi_host: sequences one cdctl QSPI register transaction (addr, optional dummy, 1..256 data bytes) per command.
// Define CDCTL_QSPI_HOST_INT_SYNC_EN to route int_n through a 2-flop synchronizer before irq.
module cdctl_qspi_host #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_len,
  output logic       wr_req,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       busy,
  output logic       nss,
  output logic       sck,
  output logic [3:0] sdio_o,
  output logic       sdio_oe,
  input  logic [3:0] sdio_i,
  input  logic       int_n,
  output logic       irq
);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, ADDR, DUMMY, DATA, CS_HOLD, GAP
  } state_t;

  localparam logic [8:0] DIV_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] DIV_PRE  = 9'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
  // The IDLE accept cycle also has nss high, so GAP is one cycle short of 2*CLK_DIV.
  localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 2);

  state_t     state;
  logic [8:0] cnt;
  logic [1:0] half;
  logic [7:0] byte_cnt;
  logic [7:0] len;
  logic [7:0] shift;
  logic       is_wr;
  logic [3:0] rx_hi;

  logic half_end, byte_end, pre_byte_end, last_byte;

  assign half_end     = (cnt == DIV_LAST);
  assign byte_end     = half_end && (half == 2'd3);
  assign pre_byte_end = (CLK_DIV == 1) ? (half == 2'd2) : ((half == 2'd3) && (cnt == DIV_PRE));
  assign last_byte    = (byte_cnt == len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      half      <= '0;
      byte_cnt  <= '0;
      len       <= '0;
      shift     <= '0;
      is_wr     <= 1'b0;
      rx_hi     <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      nss       <= 1'b1;
      sck       <= 1'b0;
      sdio_o    <= '0;
      sdio_oe   <= 1'b0;
      wr_req    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
    end else begin
      wr_req   <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            state     <= CS_SETUP;
            is_wr     <= cmd_wr;
            len       <= cmd_len;
            shift     <= {cmd_wr, cmd_addr};
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            nss       <= 1'b0;
            cnt       <= '0;
          end
        end
        CS_SETUP: begin
          if (half_end) begin
            state   <= ADDR;
            cnt     <= '0;
            half    <= '0;
            sdio_o  <= shift[7:4];
            sdio_oe <= 1'b1;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        ADDR, DUMMY, DATA: begin
          // Four half-periods per byte: low/high for the high nibble, then low/high for the low nibble.
          if (half_end) begin
            cnt  <= '0;
            half <= half + 2'd1;
            sck  <= ~half[0];
          end else begin
            cnt <= cnt + 9'd1;
          end
          if (pre_byte_end && is_wr && ((state == ADDR) || ((state == DATA) && !last_byte)))
            wr_req <= 1'b1;
          if (half_end && (half == 2'd1) && ((state == ADDR) || ((state == DATA) && is_wr)))
            sdio_o <= shift[3:0];
          if ((state == DATA) && !is_wr && half_end) begin
            if (half == 2'd0)
              rx_hi <= sdio_i;
            if (half == 2'd2) begin
              rd_valid <= 1'b1;
              rd_data  <= {rx_hi, sdio_i};
            end
          end
          if (byte_end) begin
            case (state)
              ADDR: begin
                byte_cnt <= '0;
                if (is_wr) begin
                  state  <= DATA;
                  shift  <= wr_data;
                  sdio_o <= wr_data[7:4];
                end else begin
                  state   <= DUMMY;
                  sdio_oe <= 1'b0;
                end
              end
              DUMMY: state <= DATA;
              default: begin
                if (last_byte) begin
                  state <= CS_HOLD;
                end else begin
                  byte_cnt <= byte_cnt + 8'd1;
                  if (is_wr) begin
                    shift  <= wr_data;
                    sdio_o <= wr_data[7:4];
                  end
                end
              end
            endcase
          end
        end
        CS_HOLD: begin
          if (half_end) begin
            state   <= GAP;
            cnt     <= '0;
            nss     <= 1'b1;
            done    <= 1'b1;
            sdio_oe <= 1'b0;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CDCTL_QSPI_HOST_INT_SYNC_EN
  logic irq_meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_meta <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq_meta <= ~int_n;
      irq      <= irq_meta;
    end
  end
`else
  assign irq = ~int_n;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdctl_qspi_host.sv
`default_nettype none
// tb_cdctl_qspi_host: randomized transactions against a byte/nibble-level model of the cdctl QSPI protocol.
module tb_cdctl_qspi_host;

  localparam int CLK_DIV = 2;
  localparam int LIMIT   = 20000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_wr = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic       wr_req;
  logic [7:0] wr_data = '0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       done;
  logic       busy;
  logic       nss;
  logic       sck;
  logic [3:0] sdio_o;
  logic       sdio_oe;
  logic [3:0] sdio_i = '0;
  logic       int_n = 1'b1;
  logic       irq;

  cdctl_qspi_host #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_req(wr_req), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy),
    .nss(nss), .sck(sck), .sdio_o(sdio_o), .sdio_oe(sdio_oe), .sdio_i(sdio_i),
    .int_n(int_n), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave-side model state, observed at the falling clk edge.
  logic [7:0] wr_bytes [256];
  logic [7:0] rd_bytes [256];
  logic [3:0] nib_q [$];
  logic [7:0] rd_q [$];
  int nss_low = 0, rises = 0, wr_cnt = 0, done_cnt = 0, hi_run = 0, hi_run_last = 0, viol = 0;
  logic prev_nss = 1'b1, prev_sck = 1'b0;
  logic [3:0] prev_sdio = '0;

  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (nss === 1'b0 && prev_nss === 1'b1) begin
        hi_run_last = hi_run;
        hi_run = 0; nss_low = 0; rises = 0; wr_cnt = 0; done_cnt = 0;
        nib_q.delete(); rd_q.delete();
      end
      if (nss) hi_run++; else nss_low++;
      if (!nss && sck && !prev_sck) begin
        rises++;
        if (sdio_oe) nib_q.push_back(sdio_o);
      end
      // Present the next nibble during the low phase; addr and dummy occupy the first four rises.
      if (!nss && !sck && rises >= 4) begin
        k = ((rises - 4) / 2) % 256;
        sdio_i = ((rises - 4) % 2 == 0) ? rd_bytes[k][7:4] : rd_bytes[k][3:0];
      end
      if (wr_req) begin
        wr_data = wr_bytes[wr_cnt % 256];
        wr_cnt++;
      end
      if (rd_valid) rd_q.push_back(rd_data);
      if (done) done_cnt++;
      if (!reset) begin
        if (sck && (sdio_o !== prev_sdio)) viol++;
        if (cmd_ready && busy) viol++;
        if (cmd_ready && !nss) viol++;
        if (nss && sck) viol++;
      end
      prev_nss = nss; prev_sck = sck; prev_sdio = sdio_o;
    end
  end

  task automatic run_txn(input bit wr, input logic [6:0] addr, input logic [7:0] len,
                         input bit hold, input bit keep_data);
    int n, cyc, errs, exp_low;
    logic [7:0] hdr;
    logic [3:0] exp_nib [$];
    n = int'(len) + 1;
    if (!keep_data)
      for (int i = 0; i < n; i++) begin
        wr_bytes[i] = 8'($urandom);
        rd_bytes[i] = 8'($urandom);
      end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
    cyc = 0;
    while (!cmd_ready && cyc < LIMIT) begin @(negedge clk); cyc++; end
    check("accept_in_time", 32'(cyc < LIMIT), 1);
    @(negedge clk);
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_wr = 1'($urandom); cmd_addr = 7'($urandom); cmd_len = 8'($urandom);
    end
    cyc = 0;
    while (!done && cyc < LIMIT) begin @(negedge clk); cyc++; end
    check("done_in_time", 32'(cyc < LIMIT), 1);
    @(negedge clk);

    hdr = {wr, addr};
    exp_nib.push_back(hdr[7:4]);
    exp_nib.push_back(hdr[3:0]);
    if (wr)
      for (int i = 0; i < n; i++) begin
        exp_nib.push_back(wr_bytes[i][7:4]);
        exp_nib.push_back(wr_bytes[i][3:0]);
      end
    check("nib_count", nib_q.size(), exp_nib.size());
    errs = 0;
    for (int i = 0; i < exp_nib.size() && i < nib_q.size(); i++)
      if (nib_q[i] !== exp_nib[i]) errs++;
    check("nib_data", errs, 0);

    exp_low = CLK_DIV + 4 * CLK_DIV * (1 + (wr ? 0 : 1) + n) + CLK_DIV;
    check("nss_low_cycles", nss_low, exp_low);
    check("wr_req_count", wr_cnt, wr ? n : 0);
    check("rd_count", rd_q.size(), wr ? 0 : n);
    errs = 0;
    for (int i = 0; i < rd_q.size() && i < n; i++)
      if (rd_q[i] !== rd_bytes[i]) errs++;
    check("rd_data", errs, 0);
    check("done_count", done_cnt, 1);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check("rst_nss", nss, 1);
    check("rst_sck", sck, 0);
    check("rst_oe", sdio_oe, 0);
    check("rst_sdio_o", sdio_o, 0);
    check("rst_wr_req", wr_req, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_irq", irq, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    // Directed write: addr 0x03, one byte 0x5A -> nibbles 8,3,5,A over 20 nss-low cycles.
    wr_bytes[0] = 8'h5A;
    run_txn(1'b1, 7'h03, 8'd0, 1'b0, 1'b1);

    // Directed read: addr 0x10, two bytes returned C3, 7E.
    rd_bytes[0] = 8'hC3;
    rd_bytes[1] = 8'h7E;
    run_txn(1'b0, 7'h10, 8'd1, 1'b0, 1'b1);

    // Back-to-back with cmd_valid held across the boundary.
    run_txn(1'b1, 7'($urandom), 8'd1, 1'b1, 1'b0);
    run_txn(1'b0, 7'($urandom), 8'd0, 1'b0, 1'b0);
    check("b2b_gap", hi_run_last, 2 * CLK_DIV);

    // Maximum length write: 256 byte pulls.
    run_txn(1'b1, 7'h7F, 8'd255, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++)
      run_txn(1'($urandom), 7'($urandom), 8'($urandom_range(0, 4)), 1'b0, 1'b0);

    // Abort a write during its second data byte.
    for (int i = 0; i < 4; i++) wr_bytes[i] = 8'($urandom);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 7'h22; cmd_len = 8'd3;
    cyc = 0;
    while (!cmd_ready && cyc < LIMIT) begin @(negedge clk); cyc++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (wr_cnt < 2 && cyc < LIMIT) begin @(negedge clk); cyc++; end
    check("abort_reached_byte2", 32'(cyc < LIMIT), 1);
    repeat (3) @(negedge clk);
    check("abort_in_data", nss, 0);
    #1 reset = 1'b1;
    #1;
    check("abort_nss", nss, 1);
    check("abort_sck", sck, 0);
    check("abort_oe", sdio_oe, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", cmd_ready, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_ready_after", cmd_ready, 1);
    run_txn(1'b1, 7'h22, 8'd2, 1'b0, 1'b0);

    // Interrupt path.
    @(negedge clk);
    int_n = 1'b0;
    #1;
`ifdef CDCTL_QSPI_HOST_INT_SYNC_EN
    check("irq_not_yet", irq, 0);
    @(posedge clk); #1;
    check("irq_one_cycle", irq, 0);
    @(posedge clk); #1;
    check("irq_two_cycles", irq, 1);
`else
    check("irq_immediate", irq, 1);
`endif
    @(negedge clk);
    int_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("irq_released", irq, 0);

    check("protocol_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/cdctl_qspi_host.md
CDCTL_QSPI_HOST -- requirements
Module: cdctl_qspi_host

Interface
REQ-001 SHALL have parameter: CLK_DIV, 2, SCK half-period in clk cycles (legal 1..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: cmd_valid in 1 request; cmd_ready out 1 accept; cmd_wr in 1 (1=write); cmd_addr in 7 register address; cmd_len in 8 data bytes minus one.
REQ-005 SHALL have ports: wr_req out 1 byte-pull pulse; wr_data in 8 write byte.
REQ-006 SHALL have ports: rd_valid out 1 byte pulse; rd_data out 8 read byte; done out 1 transaction-end pulse; busy out 1.
REQ-007 SHALL have ports: nss out 1; sck out 1; sdio_o out 4; sdio_oe out 1; sdio_i in 4; pad tri-state is external.
REQ-008 SHALL have ports: int_n in 1 from cdctl; irq out 1 active-high interrupt.

Function
REQ-009 SHALL sequence one cdctl QSPI register transaction per accepted command; accept when cmd_valid && cmd_ready.
REQ-010 SHALL run FSM IDLE -> CS_SETUP -> ADDR -> (DUMMY if read) -> DATA -> CS_HOLD -> GAP -> IDLE.
REQ-011 cmd_ready SHALL be high only in IDLE; busy SHALL be high in every other state.
REQ-012 Accept SHALL latch cmd_wr/addr/len and drive nss low next cycle; CS_SETUP lasts CLK_DIV cycles, sck low.
REQ-013 Each byte SHALL be 2 SCK periods, high nibble first; sck low CLK_DIV cycles then high CLK_DIV cycles.
REQ-014 sdio_o SHALL change only while sck low (at the start of the low phase); cdctl samples on sck rise.
REQ-015 ADDR byte SHALL be {cmd_wr, cmd_addr}, sdio_oe=1.
REQ-016 Read SHALL insert DUMMY of one byte time (4*CLK_DIV cycles), sdio_oe=0 from DUMMY start to CS_HOLD end.
REQ-017 DATA SHALL transfer cmd_len+1 bytes (1..256); counter is 8 bits, cmd_len=255 yields 256 bytes, no wrap to 0.
REQ-018 Write: wr_req SHALL pulse one cycle on the cycle before each data byte's first nibble is driven; wr_data captured on that cycle.
REQ-019 Read: sdio_i SHALL be sampled on the clk cycle sck rises; rd_valid SHALL pulse one cycle after the second nibble is sampled, rd_data held until next byte.
REQ-020 CS_HOLD SHALL last CLK_DIV cycles with sck low; nss rises and done pulses on the same cycle CS_HOLD exits.
REQ-021 GAP SHALL hold nss high for 2*CLK_DIV cycles before cmd_ready rises; cmd_valid during GAP waits.
REQ-022 cmd_* changes while busy SHALL be ignored.
REQ-023 int_n SHALL not affect the FSM; irq reflects only ~int_n.

Reset
REQ-024 reset SHALL asynchronously force IDLE: nss=1, sck=0, sdio_oe=0, sdio_o=0, wr_req=0, rd_valid=0, rd_data=0, done=0, busy=0, irq=0.
REQ-025 cmd_ready SHALL be 0 while reset high, 1 on first cycle after release.
REQ-026 reset mid-transaction SHALL abort without done pulse; next command starts a clean transaction.

Configuration
REQ-027 Macro CDCTL_QSPI_HOST_INT_SYNC_EN defined: irq SHALL be ~int_n through a 2-flop synchronizer (2-cycle latency).
REQ-028 Macro undefined: irq SHALL be combinational ~int_n (zero latency); all other behaviour identical.

Verification
REQ-029 CLK_DIV=2, write addr 0x03 len 0 data 0x5A -> sdio_o nibbles 8,3,5,A; nss low 20 cycles; one wr_req; done once.
REQ-030 CLK_DIV=2, read addr 0x10 len 1, slave returns 0xC3,0x7E -> sdio_o nibbles 1,0; oe low from DUMMY; rd_valid twice with C3,7E; nss low 36 cycles.
REQ-031 Back-to-back cmd_valid held high -> nss high exactly 4 cycles (CLK_DIV=2) between transactions; cmd_ready only in IDLE.
REQ-032 Write len 255 -> exactly 256 wr_req pulses, then done.
REQ-033 Assert reset during DATA byte 2 -> nss=1, sck=0, oe=0 same cycle; no done; subsequent write completes correctly.
REQ-034 Toggle int_n low -> irq high after 2 cycles with CDCTL_QSPI_HOST_INT_SYNC_EN, immediately without.
